// File: rtl/rv_pkg.sv
// Shared RISC-V softcore definitions: load/store opcodes, memory funct3 codes
// and the load/store unit state encoding.
package rv_pkg;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_BUS  = 2'd1,
    LSU_DONE = 2'd2
  } lsu_state_e;

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane logic for the load/store unit: store byte enables, lane-replicated
// write data and legality on the request side; lane select and extension on the load side.
module lsu_lane_align
  import rv_pkg::*;
(
  input  logic [2:0]  st_funct3,
  input  logic [1:0]  st_addr,
  input  logic        st_write,
  input  logic [31:0] st_data,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata,
  output logic        st_illegal,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_addr,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_result
);

  logic [31:0] ld_shifted;

  always_comb begin
    st_be      = 4'b0000;
    st_wdata   = st_data;
    st_illegal = 1'b0;
    case (st_funct3)
      F3_B, F3_BU: begin
        st_be    = 4'b0001 << st_addr;
        st_wdata = {4{st_data[7:0]}};
      end
      F3_H, F3_HU: begin
        st_be      = st_addr[1] ? 4'b1100 : 4'b0011;
        st_wdata   = {2{st_data[15:0]}};
        st_illegal = st_addr[0];
      end
      F3_W: begin
        st_be      = 4'b1111;
        st_illegal = (st_addr != 2'b00);
      end
      default: st_illegal = 1'b1;
    endcase
    // Unsigned variants only exist for loads.
    if (st_write && st_funct3[2]) st_illegal = 1'b1;
  end

  // Shifting the addressed lane down to bit 0 serves both byte and half accesses.
  always_comb begin
    ld_shifted = ld_rdata >> {ld_addr, 3'b000};
    case (ld_funct3)
      F3_B:    ld_result = {{24{ld_shifted[7]}}, ld_shifted[7:0]};
      F3_BU:   ld_result = {24'h000000, ld_shifted[7:0]};
      F3_H:    ld_result = {{16{ld_shifted[15]}}, ld_shifted[15:0]};
      F3_HU:   ld_result = {16'h0000, ld_shifted[15:0]};
      default: ld_result = ld_rdata;
    endcase
  end

endmodule

// File: rtl/lsu_controller.sv
// Multi-cycle load/store sequencer driving a req/ack data bus.
// Optional bus timeout enabled by defining LSU_TIMEOUT_EN.
module lsu_controller
  import rv_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        mem_write_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] store_data_i,
  output logic        stall_o,
  output logic        done_o,
  output logic [31:0] load_data_o,
  output logic        fault_o,
  output logic        bus_error_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_rdata_i
);

  lsu_state_e  state, state_next;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [1:0]  alo_q;
  logic [31:0] addr_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic        fault_q;
  logic        err_q;
  logic [31:0] load_q;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;
  logic [31:0] load_c;
  logic        illegal_c;
  logic        timeout;

  lsu_lane_align u_align (
    .st_funct3  (funct3_i),
    .st_addr    (addr_i[1:0]),
    .st_write   (mem_write_i),
    .st_data    (store_data_i),
    .st_be      (be_c),
    .st_wdata   (wdata_c),
    .st_illegal (illegal_c),
    .ld_funct3  (f3_q),
    .ld_addr    (alo_q),
    .ld_rdata   (bus_rdata_i),
    .ld_result  (load_c)
  );

`ifdef LSU_TIMEOUT_EN
  localparam int CntW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CntW-1:0] cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i || (state != LSU_BUS)) cnt <= '0;
    else if (!bus_ack_i) cnt <= cnt + CntW'(1);
  end

  // Fires in the last allowed BUS cycle, so req is high for exactly TIMEOUT_CYCLES cycles.
  assign timeout = (state == LSU_BUS) && !bus_ack_i && (cnt == CntW'(TIMEOUT_CYCLES - 1));
`else
  // TIMEOUT_CYCLES is never negative, so this is a constant 0.
  assign timeout = (TIMEOUT_CYCLES < 0);
`endif

  always_comb begin
    state_next = state;
    case (state)
      LSU_IDLE: if (start_i) state_next = illegal_c ? LSU_DONE : LSU_BUS;
      LSU_BUS:  if (bus_ack_i || timeout) state_next = LSU_DONE;
      LSU_DONE: state_next = LSU_IDLE;
      default:  state_next = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= LSU_IDLE;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      alo_q   <= 2'b00;
      addr_q  <= '0;
      be_q    <= 4'b0000;
      wdata_q <= '0;
      fault_q <= 1'b0;
      err_q   <= 1'b0;
      load_q  <= '0;
    end else begin
      state <= state_next;
      if ((state == LSU_IDLE) && start_i) begin
        fault_q <= illegal_c;
        err_q   <= 1'b0;
        if (!illegal_c) begin
          we_q    <= mem_write_i;
          f3_q    <= funct3_i;
          alo_q   <= addr_i[1:0];
          addr_q  <= {addr_i[31:2], 2'b00};
          be_q    <= be_c;
          wdata_q <= wdata_c;
        end
      end
      if (state == LSU_BUS) begin
        if (bus_ack_i) begin
          if (!we_q) load_q <= load_c;
        end else if (timeout) begin
          err_q <= 1'b1;
        end
      end
    end
  end

  assign stall_o     = ((state == LSU_IDLE) && start_i) || (state == LSU_BUS);
  assign done_o      = (state == LSU_DONE);
  assign fault_o     = (state == LSU_DONE) && fault_q;
  assign bus_error_o = (state == LSU_DONE) && err_q;
  assign bus_req_o   = (state == LSU_BUS);
  assign bus_we_o    = (state == LSU_BUS) && we_q;
  assign bus_addr_o  = addr_q;
  assign bus_be_o    = be_q;
  assign bus_wdata_o = wdata_q;
  assign load_data_o = load_q;

endmodule

// File: tb/tb_lsu_controller.sv
// Self-checking bench for lsu_controller: directed cases plus randomized
// transactions checked against a behavioural memory-access model.
module tb_lsu_controller;

  localparam int MAX_CYC = 300;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic        mem_write_i = 1'b0;
  logic [2:0]  funct3_i = 3'b000;
  logic [31:0] addr_i = '0;
  logic [31:0] store_data_i = '0;
  logic        stall_o, done_o, fault_o, bus_error_o;
  logic [31:0] load_data_o;
  logic        bus_req_o, bus_we_o;
  logic [31:0] bus_addr_o, bus_wdata_o;
  logic [3:0]  bus_be_o;
  logic        bus_ack_i = 1'b0;
  logic [31:0] bus_rdata_i = '0;

  int n_pass = 0;
  int n_total = 0;

  int          obs_stall, obs_req, obs_done_cyc;
  logic        obs_fault, obs_berr, obs_we, obs_stable, obs_held, obs_clean;
  logic [31:0] obs_addr, obs_wdata, obs_load;
  logic [3:0]  obs_be;
  logic [31:0] model_load = '0;

  lsu_controller #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .mem_write_i(mem_write_i),
    .funct3_i(funct3_i), .addr_i(addr_i), .store_data_i(store_data_i),
    .stall_o(stall_o), .done_o(done_o), .load_data_o(load_data_o),
    .fault_o(fault_o), .bus_error_o(bus_error_o), .bus_req_o(bus_req_o),
    .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o), .bus_be_o(bus_be_o),
    .bus_wdata_o(bus_wdata_o), .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i)
  );

  always #5 clk = ~clk;

  // Reference model: access size in bytes from the funct3 code.
  function automatic int m_size(input logic [2:0] f3);
    if (f3[1:0] == 2'd0) return 1;
    if (f3[1:0] == 2'd1) return 2;
    return 4;
  endfunction

  function automatic bit m_illegal(input bit we, input logic [2:0] f3, input logic [31:0] addr);
    if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
    if (we && f3 >= 3'd4) return 1'b1;
    return (int'(addr[1:0]) % m_size(f3)) != 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] addr);
    int s;
    s = m_size(f3);
    return 4'(((1 << s) - 1) << int'(addr[1:0]));
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] r;
    int s;
    s = m_size(f3);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = 8'(d >> (8 * (i % s)));
    return r;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rdata);
    logic [31:0] v, mask;
    int s;
    s = m_size(f3);
    v = rdata >> (8 * int'(addr[1:0]));
    if (s == 4) return v;
    mask = (32'd1 << (8 * s)) - 32'd1;
    v = v & mask;
    if (f3 < 3'd4 && v[8*s-1]) v = v | ~mask;
    return v;
  endfunction

  // Drives one request and records what the bus and pipeline sides saw.
  // ack_at is the 1-based BUS cycle that gets bus_ack_i; 0 means never.
  task automatic run_txn(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] data, input logic [31:0] rdata, input int ack_at);
    logic [31:0] load_before;
    obs_stall = 0; obs_req = 0; obs_done_cyc = -1;
    obs_fault = 0; obs_berr = 0; obs_stable = 1; obs_held = 1; obs_clean = 1;
    obs_we = 0; obs_addr = '0; obs_wdata = '0; obs_be = '0; obs_load = '0;
    load_before = load_data_o;
    mem_write_i = we; funct3_i = f3; addr_i = addr; store_data_i = data;
    bus_rdata_i = rdata; start_i = 1'b1;
    for (int cyc = 0; cyc < MAX_CYC && obs_done_cyc < 0; cyc++) begin
      bus_ack_i = 1'b0;
      #1;
      if (stall_o) obs_stall++;
      if (bus_req_o) begin
        obs_req++;
        if (obs_req == 1) begin
          obs_we = bus_we_o; obs_addr = bus_addr_o; obs_be = bus_be_o; obs_wdata = bus_wdata_o;
        end else if (bus_we_o !== obs_we || bus_addr_o !== obs_addr ||
                     bus_be_o !== obs_be || bus_wdata_o !== obs_wdata) begin
          obs_stable = 0;
        end
        if (obs_req == ack_at) bus_ack_i = 1'b1;
      end
      if (done_o) begin
        obs_done_cyc = cyc; obs_fault = fault_o; obs_berr = bus_error_o; obs_load = load_data_o;
        start_i = 1'b0;
      end else if (load_data_o !== load_before) begin
        obs_held = 0;
      end
      @(negedge clk);
    end
    start_i = 1'b0; bus_ack_i = 1'b0;
    #1;
    if (done_o || fault_o || bus_error_o || bus_req_o || stall_o) obs_clean = 0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst_i = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_total++;
    if ({stall_o, done_o, fault_o, bus_error_o, bus_req_o, bus_we_o} !== 6'b0)
      $display("[TB] FAIL reset_flags: got %b expected 000000", {stall_o, done_o, fault_o, bus_error_o, bus_req_o, bus_we_o});
    else n_pass++;
    n_total++;
    if (load_data_o !== 32'h0) $display("[TB] FAIL reset_load: got %h expected 0", load_data_o);
    else n_pass++;
    n_total++;
    if ({bus_addr_o, bus_be_o, bus_wdata_o} !== 68'h0)
      $display("[TB] FAIL reset_bus: got addr %h be %b wdata %h expected zeros", bus_addr_o, bus_be_o, bus_wdata_o);
    else n_pass++;
    @(negedge clk);
    rst_i = 1'b0;
    model_load = '0;
    @(negedge clk);
  endtask

  typedef struct {
    bit we; logic [2:0] f3; logic [31:0] addr, data, rdata; int ack_at;
    logic [3:0] be; logic [31:0] wdata, load;
  } dir_t;

  task automatic test_directed;
    dir_t tbl[6];
    tbl[0] = '{1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 1, 4'b1111, 32'h0, 32'hDEADBEEF};
    tbl[1] = '{1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF0000, 1, 4'b1000, 32'h0, 32'hFFFFFF80};
    tbl[2] = '{1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF0000, 2, 4'b1000, 32'h0, 32'h00000080};
    tbl[3] = '{1'b0, 3'b101, 32'h102, 32'h0, 32'h80FF0000, 1, 4'b1100, 32'h0, 32'h000080FF};
    tbl[4] = '{1'b1, 3'b000, 32'h201, 32'h123456AB, 32'h0, 1, 4'b0010, 32'hABABABAB, 32'h000080FF};
    tbl[5] = '{1'b1, 3'b001, 32'h202, 32'h123456AB, 32'h0, 3, 4'b1100, 32'h56AB56AB, 32'h000080FF};
    foreach (tbl[i]) begin
      run_txn(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].data, tbl[i].rdata, tbl[i].ack_at);
      n_total++;
      if (obs_done_cyc !== tbl[i].ack_at + 1 || obs_stall !== tbl[i].ack_at + 1 || obs_req !== tbl[i].ack_at)
        $display("[TB] FAIL dir%0d_timing: got done@%0d stall %0d req %0d expected done@%0d stall %0d req %0d",
                 i, obs_done_cyc, obs_stall, obs_req, tbl[i].ack_at + 1, tbl[i].ack_at + 1, tbl[i].ack_at);
      else n_pass++;
      n_total++;
      if (obs_be !== tbl[i].be || obs_addr !== {tbl[i].addr[31:2], 2'b00} || obs_we !== tbl[i].we)
        $display("[TB] FAIL dir%0d_bus: got be %b addr %h we %b expected be %b addr %h we %b",
                 i, obs_be, obs_addr, obs_we, tbl[i].be, {tbl[i].addr[31:2], 2'b00}, tbl[i].we);
      else n_pass++;
      if (tbl[i].we) begin
        n_total++;
        if (obs_wdata !== tbl[i].wdata) $display("[TB] FAIL dir%0d_wdata: got %h expected %h", i, obs_wdata, tbl[i].wdata);
        else n_pass++;
      end
      n_total++;
      if (obs_load !== tbl[i].load || obs_fault !== 1'b0 || obs_clean !== 1'b1)
        $display("[TB] FAIL dir%0d_result: got load %h fault %b clean %b expected load %h fault 0 clean 1",
                 i, obs_load, obs_fault, obs_clean, tbl[i].load);
      else n_pass++;
    end
    model_load = 32'h000080FF;
  endtask

  task automatic test_faults;
    logic [2:0]  f3s[4]   = '{3'b010, 3'b100, 3'b001, 3'b011};
    bit          wes[4]   = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [31:0] addrs[4] = '{32'h102, 32'h200, 32'h101, 32'h100};
    for (int i = 0; i < 4; i++) begin
      run_txn(wes[i], f3s[i], addrs[i], 32'h55AA55AA, 32'h12345678, 1);
      n_total++;
      if (obs_done_cyc !== 1 || obs_fault !== 1'b1 || obs_req !== 0 || obs_stall !== 1)
        $display("[TB] FAIL fault%0d: got done@%0d fault %b req %0d stall %0d expected done@1 fault 1 req 0 stall 1",
                 i, obs_done_cyc, obs_fault, obs_req, obs_stall);
      else n_pass++;
      n_total++;
      if (obs_load !== model_load || obs_clean !== 1'b1)
        $display("[TB] FAIL fault%0d_load: got %h clean %b expected %h clean 1", i, obs_load, obs_clean, model_load);
      else n_pass++;
    end
  endtask

  task automatic test_delayed_ack;
    run_txn(1'b0, 3'b010, 32'h300, 32'h0, 32'hCAFE0000, 1);
    n_total++;
    if (obs_load !== 32'hCAFE0000) $display("[TB] FAIL delay_preload: got %h expected cafe0000", obs_load);
    else n_pass++;
    run_txn(1'b0, 3'b010, 32'h304, 32'h0, 32'h11223344, 6);
    n_total++;
    if (obs_stable !== 1'b1 || obs_held !== 1'b1 || obs_req !== 6 || obs_stall !== 7)
      $display("[TB] FAIL delay_hold: got stable %b held %b req %0d stall %0d expected 1 1 6 7",
               obs_stable, obs_held, obs_req, obs_stall);
    else n_pass++;
    n_total++;
    if (obs_done_cyc !== 7 || obs_load !== 32'h11223344 || obs_addr !== 32'h304)
      $display("[TB] FAIL delay_result: got done@%0d load %h addr %h expected done@7 load 11223344 addr 304",
               obs_done_cyc, obs_load, obs_addr);
    else n_pass++;
    model_load = 32'h11223344;
  endtask

  task automatic test_reset_mid;
    bit bad_req, bad_done;
    bad_req = 0; bad_done = 0;
    mem_write_i = 1'b0; funct3_i = 3'b010; addr_i = 32'h400; bus_rdata_i = 32'hFFFF0000;
    start_i = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_total++;
    if (bus_req_o !== 1'b1) $display("[TB] FAIL rstmid_req_before: got %b expected 1", bus_req_o);
    else n_pass++;
    rst_i = 1'b1;
    @(negedge clk);
    #1;
    n_total++;
    if (bus_req_o !== 1'b0 || done_o !== 1'b0) $display("[TB] FAIL rstmid_after: got req %b done %b expected 0 0", bus_req_o, done_o);
    else n_pass++;
    rst_i = 1'b0; start_i = 1'b0;
    model_load = '0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      bus_ack_i = 1'b1;
      #1;
      if (done_o || bus_req_o) bad_done = 1;
      if (load_data_o !== model_load) bad_req = 1;
    end
    bus_ack_i = 1'b0;
    @(negedge clk);
    n_total++;
    if (bad_done || bad_req) $display("[TB] FAIL rstmid_late_ack: got done/req %b load_changed %b expected 0 0", bad_done, bad_req);
    else n_pass++;
  endtask

  task automatic test_random;
    bit we; logic [2:0] f3; logic [31:0] addr, data, rdata; int ack_at; bit ill;
    for (int n = 0; n < 60; n++) begin
      we = 1'($urandom_range(0, 1)); f3 = 3'($urandom_range(0, 7));
      addr = $urandom; data = $urandom; rdata = $urandom; ack_at = $urandom_range(1, 4);
      ill = m_illegal(we, f3, addr);
      run_txn(we, f3, addr, data, rdata, ack_at);
      if (ill) begin
        n_total++;
        if (obs_fault !== 1'b1 || obs_done_cyc !== 1 || obs_req !== 0 || obs_load !== model_load)
          $display("[TB] FAIL rnd%0d_fault we=%b f3=%0d addr=%h: got fault %b done@%0d req %0d load %h expected 1 1 0 %h",
                   n, we, f3, addr, obs_fault, obs_done_cyc, obs_req, obs_load, model_load);
        else n_pass++;
      end else begin
        if (!we) model_load = m_load(f3, addr, rdata);
        n_total++;
        if (obs_fault !== 1'b0 || obs_done_cyc !== ack_at + 1 || obs_req !== ack_at || obs_clean !== 1'b1)
          $display("[TB] FAIL rnd%0d_timing: got fault %b done@%0d req %0d clean %b expected 0 %0d %0d 1",
                   n, obs_fault, obs_done_cyc, obs_req, obs_clean, ack_at + 1, ack_at);
        else n_pass++;
        n_total++;
        if (obs_be !== m_be(f3, addr) || obs_addr !== {addr[31:2], 2'b00} || obs_we !== we ||
            (we && obs_wdata !== m_wdata(f3, data)))
          $display("[TB] FAIL rnd%0d_bus f3=%0d addr=%h: got be %b addr %h we %b wdata %h expected be %b wdata %h",
                   n, f3, addr, obs_be, obs_addr, obs_we, obs_wdata, m_be(f3, addr), m_wdata(f3, data));
        else n_pass++;
        n_total++;
        if (obs_load !== model_load)
          $display("[TB] FAIL rnd%0d_load f3=%0d addr=%h rdata=%h: got %h expected %h", n, f3, addr, rdata, obs_load, model_load);
        else n_pass++;
      end
    end
  endtask

`ifdef LSU_TIMEOUT_EN
  task automatic test_timeout;
    run_txn(1'b0, 3'b010, 32'h500, 32'h0, 32'h77777777, 0);
    n_total++;
    if (obs_req !== 4 || obs_done_cyc !== 5 || obs_berr !== 1'b1 || obs_load !== model_load)
      $display("[TB] FAIL timeout_abort: got req %0d done@%0d berr %b load %h expected 4 5 1 %h",
               obs_req, obs_done_cyc, obs_berr, obs_load, model_load);
    else n_pass++;
    run_txn(1'b0, 3'b010, 32'h504, 32'h0, 32'h24682468, 4);
    model_load = 32'h24682468;
    n_total++;
    if (obs_req !== 4 || obs_berr !== 1'b0 || obs_load !== model_load)
      $display("[TB] FAIL timeout_ack_wins: got req %0d berr %b load %h expected 4 0 %h",
               obs_req, obs_berr, obs_load, model_load);
    else n_pass++;
  endtask
`endif

  initial begin
    @(negedge clk);
    test_reset;
    test_directed;
    test_faults;
    test_delayed_ack;
    test_reset_mid;
    test_random;
`ifdef LSU_TIMEOUT_EN
    test_timeout;
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/lsu_controller.md
# lsu_controller

Multi-cycle load/store sequencer between the decode/control stage and the data-memory bus of the RISC-V softcore. Accepts one decoded LB/LH/LW/LBU/LHU/SB/SH/SW request at a time and stalls the core while the bus transaction is in flight. It drives a single req/ack data bus with word-aligned address, byte enables and lane-replicated store data, then returns the sign- or zero-extended load result. Alignment faults and illegal size codes are rejected without touching the bus.

## Interface
- TIMEOUT_CYCLES, 255: bus cycles waited for `bus_ack_i` before abort; used only with LSU_TIMEOUT_EN.
- clk_i  input  1  clock; all logic rising-edge.
- rst_i  input  1  reset, synchronous, active-high.
- start_i  input  1  memory instruction present; sampled only in IDLE.
- mem_write_i  input  1  1 = store, 0 = load.
- funct3_i  input  3  size/sign code, RV32I encoding.
- addr_i  input  32  effective byte address.
- store_data_i  input  32  rs2 value.
- stall_o  output  1  hold PC and pipeline registers.
- done_o  output  1  one-cycle completion pulse, load or store.
- load_data_o  output  32  extended load result, held until next load completes.
- fault_o  output  1  one-cycle pulse: misaligned address or illegal funct3.
- bus_error_o  output  1  one-cycle pulse: bus timeout; constant 0 without LSU_TIMEOUT_EN.
- bus_req_o  output  1  bus request, held until ack.
- bus_we_o  output  1  write strobe.
- bus_addr_o  output  32  `{addr[31:2], 2'b00}`.
- bus_be_o  output  4  byte enables.
- bus_wdata_o  output  32  lane-replicated store data.
- bus_ack_i  input  1  transfer complete; `bus_rdata_i` valid in the same cycle.
- bus_rdata_i  input  32  read word.

## Operation
- States: IDLE, BUS, DONE.
- IDLE, start_i=1, legal request: latch we, funct3, addr[1:0], be and wdata; go to BUS.
- IDLE, start_i=1, illegal request: go to DONE with fault pending; no bus activity.
  - Illegal: funct3 ∈ {011, 110, 111}; store with funct3[2]=1; half access with addr[0]=1; word access with addr[1:0]≠0.
- BUS: bus outputs are registered and stable while req=1. On bus_ack_i, capture data (loads only) and go to DONE.
- DONE: done_o=1; fault_o=1 if a fault is pending. Next state is always IDLE.
- Byte enables:
  - byte access: 0001 shifted left by addr[1:0].
  - half access: 0011 if addr[1]=0, else 1100.
  - word access: 1111.
- Store data:
  - SB: `{4{d[7:0]}}`.
  - SH: `{2{d[15:0]}}`.
  - SW: d.
- Load data: select the lane by the latched addr[1:0]. Extend with the lane's MSB when funct3[2]=0, otherwise zero-extend.
- load_data_o updates only on successful loads. Stores, faults and timeouts leave it unchanged.
- bus_ack_i outside BUS is ignored.

## Timing
- Reset values: state IDLE; all outputs 0, including load_data_o; timeout counter 0.
- stall_o is combinational: (IDLE & start_i) | BUS. It is 0 in DONE, so the pipeline advances on the DONE edge.
- bus_req_o rises the cycle after start_i is accepted.
- Ack in the first BUS cycle gives minimum legal latency: start → DONE in 2 cycles, stall_o high for 2 cycles.
- Fault path: start → DONE in 1 cycle; fault_o and done_o high in the same cycle.
- start_i in BUS or DONE is ignored. The core holds the instruction until stall_o falls.
- Reset mid-transaction: bus_req_o is 0 in the cycle after the reset edge. No done_o is produced, and a late ack is ignored.

## Configuration
- LSU_TIMEOUT_EN defined:
  - An 8+ bit counter, sized by $clog2(TIMEOUT_CYCLES+1), clears on BUS entry and increments each BUS cycle without ack.
  - When the count reaches TIMEOUT_CYCLES, drop req and go to DONE with bus_error_o=1 and done_o=1.
  - If ack arrives in the same cycle as the timeout, ack wins.
- LSU_TIMEOUT_EN undefined: no counter; BUS waits indefinitely; bus_error_o is tied 0.

## Structure
- Shared package `rv_pkg`: load/store opcode constant (shared with control_logic), funct3 constants F3_B/F3_H/F3_W/F3_BU/F3_HU, lsu state enum.
- Sub-module `lsu_lane_align` (combinational) holds the lane logic:
  - store side: funct3 + addr[1:0] + data → be, wdata, illegal.
  - load side: funct3 + addr[1:0] + rdata → extended result.

## Test plan
- LW addr 0x100, ack on first BUS cycle, rdata 0xDEADBEEF → bus_addr 0x100, be 1111; load_data 0xDEADBEEF; stall high 2 cycles; done_o pulse.
- LB addr 0x103, rdata 0x80FF_0000 → be 1000, load_data 0xFFFFFF80. LBU same → 0x00000080. LHU addr 0x102 → 0x000080FF.
- SB addr 0x201, data 0x123456AB → bus_we 1, be 0010, wdata 0xABABABAB. SH addr 0x202 → be 1100, wdata 0x56AB56AB.
- LW addr 0x102 and SW with funct3 100 → fault_o pulse after 1 cycle; bus_req never asserted; load_data unchanged.
- Ack delayed 5 cycles with load_data previously 0xCAFE0000 → req and addr stable throughout. Assert rst_i during cycle 3 of a second load → req 0 next cycle, no done_o, late ack ignored.
- LSU_TIMEOUT_EN with TIMEOUT_CYCLES=4, no ack → req drops after 4 BUS cycles; bus_error_o and done_o pulse. Ack exactly on cycle 4 → normal completion, no bus_error_o.
